// File: rtl/divide_pkg.sv
// Shared types and helpers for the iterative signed fixed-point divider.
//   state_t  : controller states (IDLE, CALC, FIX, WRITE)
//   FLAG_SAT : flags bit set when the result was clamped
//   FLAG_DBZ : flags bit set when the divisor was zero
//   n_iter() : number of CALC cycles for a given width / radix
package divide_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIX   = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int FLAG_SAT = 0;
  localparam int FLAG_DBZ = 1;

  // ceil((d + q) / b): the shifted numerator is d+q bits wide and each
  // CALC cycle retires b quotient bits.
  function automatic int n_iter(input int d, input int q, input int b);
    return (d + q + b - 1) / b;
  endfunction

endpackage

// File: rtl/divide_stage.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder entering the step (D_BITS+1 bits)
//   quo_in  : numerator/quotient shift register; its MSB is the next
//             numerator bit, the resolved quotient bit enters at the LSB
//   divisor : divisor magnitude
//   rem_out : partial remainder after the trial subtraction
//   quo_out : shift register advanced by one bit
module divide_stage #(
  parameter int D_BITS = 32,
  parameter int W      = 42
) (
  input  logic [D_BITS:0]   rem_in,
  input  logic [W-1:0]      quo_in,
  input  logic [D_BITS-1:0] divisor,
  output logic [D_BITS:0]   rem_out,
  output logic [W-1:0]      quo_out
);

  logic [D_BITS+1:0] trial;
  logic              ge;

  always_comb begin
    trial = {rem_in, quo_in[W-1]};
    ge    = trial >= {2'b00, divisor};
    if (ge) begin
      rem_out = (D_BITS+1)'(trial - {2'b00, divisor});
    end else begin
      rem_out = (D_BITS+1)'(trial);
    end
    quo_out = {quo_in[W-2:0], ge};
  end

endmodule

// File: rtl/divide_iter.sv
// Iterative signed fixed-point divider: quotient = (dividend << Q_BITS) / divisor.
// Pops operands from a show-ahead input FIFO, pushes the result plus status
// flags to an output FIFO. Latency is fixed at N_ITER+2 cycles from pop to
// push regardless of operand values (divide-by-zero still runs CALC).
//
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   dividend   : signed operand, valid while in_empty=0
//   divisor    : signed operand, valid while in_empty=0
//   in_empty   : input FIFO empty
//   in_rd_en   : input FIFO pop; operands are captured in this cycle
//   quotient   : signed fixed-point result, held until pushed
//   flags      : [FLAG_SAT] clamped result, [FLAG_DBZ] divisor was zero
//   out_wr_en  : output FIFO push
//   out_full   : output FIFO full
//
// Build option: define DIVIDE_ROUND_EN to round half away from zero;
// otherwise the result is truncated toward zero.
//
// state | meaning
// IDLE  | wait for operands, pop and capture magnitudes/sign
// CALC  | restoring division, BITS_PER_CYCLE quotient bits per cycle
// FIX   | round, apply sign, saturate or substitute DBZ result
// WRITE | present result until the output FIFO accepts it
module divide_iter
  import divide_pkg::*;
#(
  parameter int Q_BITS         = 10,
  parameter int D_BITS         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [D_BITS-1:0] dividend,
  input  logic [D_BITS-1:0] divisor,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [D_BITS-1:0] quotient,
  output logic [1:0]        flags,
  output logic              out_wr_en,
  input  logic              out_full
);

  localparam int N_ITER = n_iter(D_BITS, Q_BITS, BITS_PER_CYCLE);
  localparam int NUM_W  = N_ITER * BITS_PER_CYCLE;
  localparam int ITER_W = $clog2(N_ITER + 1);

  localparam logic [D_BITS-1:0] QUO_MAX = {1'b0, {(D_BITS-1){1'b1}}};
  localparam logic [D_BITS-1:0] QUO_MIN = {1'b1, {(D_BITS-1){1'b0}}};
  localparam logic [NUM_W:0] MAG_MAX_POS = {{(NUM_W-D_BITS+2){1'b0}}, {(D_BITS-1){1'b1}}};
  localparam logic [NUM_W:0] MAG_MAX_NEG = MAG_MAX_POS + 1'b1;

  state_t              state, next_state;
  logic [ITER_W-1:0]   iter;
  logic                sign_q;
  logic                dbz;
  logic [D_BITS-1:0]   div_mag;
  logic [D_BITS:0]     rem;
  logic [NUM_W-1:0]    qr;

  logic [D_BITS-1:0]   abs_dividend;
  logic [D_BITS-1:0]   abs_divisor;
  logic [NUM_W:0]      mag_rnd;
  logic [D_BITS-1:0]   mag_lo;
  logic [D_BITS-1:0]   fix_quo;
  logic [1:0]          fix_flags;

  // Restoring step chain: BITS_PER_CYCLE steps evaluated per CALC cycle.
  logic [D_BITS:0]  rem_chain [0:BITS_PER_CYCLE];
  logic [NUM_W-1:0] qr_chain  [0:BITS_PER_CYCLE];

  assign rem_chain[0] = rem;
  assign qr_chain[0]  = qr;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_stage
    divide_stage #(
      .D_BITS (D_BITS),
      .W      (NUM_W)
    ) u_stage (
      .rem_in  (rem_chain[g]),
      .quo_in  (qr_chain[g]),
      .divisor (div_mag),
      .rem_out (rem_chain[g+1]),
      .quo_out (qr_chain[g+1])
    );
  end

  // The most negative operand maps to 2^(D_BITS-1), which still fits unsigned.
  assign abs_dividend = dividend[D_BITS-1] ? -dividend : dividend;
  assign abs_divisor  = divisor[D_BITS-1]  ? -divisor  : divisor;

`ifdef DIVIDE_ROUND_EN
  logic round_up;
  assign round_up = {rem, 1'b0} >= {2'b00, div_mag};
  assign mag_rnd  = {1'b0, qr} + {{NUM_W{1'b0}}, round_up};
`else
  assign mag_rnd  = {1'b0, qr};
`endif

  assign mag_lo = mag_rnd[D_BITS-1:0];

  always_comb begin
    fix_quo   = sign_q ? -mag_lo : mag_lo;
    fix_flags = '0;
    if (dbz) begin
      // Divisor is zero here, so sign_q is the dividend's sign.
      fix_quo             = sign_q ? QUO_MIN : QUO_MAX;
      fix_flags[FLAG_DBZ] = 1'b1;
    end else if (!sign_q && (mag_rnd > MAG_MAX_POS)) begin
      fix_quo             = QUO_MAX;
      fix_flags[FLAG_SAT] = 1'b1;
    end else if (sign_q && (mag_rnd > MAG_MAX_NEG)) begin
      fix_quo             = QUO_MIN;
      fix_flags[FLAG_SAT] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake outputs are gated by reset so nothing pops or pushes while held.
  always_comb begin
    next_state = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    case (state)
      IDLE: begin
        in_rd_en = reset & ~in_empty;
        if (!in_empty) next_state = CALC;
      end
      CALC: begin
        if (iter == ITER_W'(1)) next_state = FIX;
      end
      FIX: begin
        next_state = WRITE;
      end
      WRITE: begin
        out_wr_en = reset & ~out_full;
        if (!out_full) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iter     <= '0;
      sign_q   <= 1'b0;
      dbz      <= 1'b0;
      div_mag  <= '0;
      rem      <= '0;
      qr       <= '0;
      quotient <= '0;
      flags    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_rd_en) begin
            sign_q  <= dividend[D_BITS-1] ^ divisor[D_BITS-1];
            dbz     <= (divisor == '0);
            div_mag <= abs_divisor;
            rem     <= '0;
            qr      <= NUM_W'({abs_dividend, {Q_BITS{1'b0}}});
            iter    <= ITER_W'(N_ITER);
          end
        end
        CALC: begin
          rem  <= rem_chain[BITS_PER_CYCLE];
          qr   <= qr_chain[BITS_PER_CYCLE];
          iter <= iter - 1'b1;
        end
        FIX: begin
          quotient <= fix_quo;
          flags    <= fix_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_iter.sv
// Directed self-checking bench for divide_iter (Q_BITS=10, D_BITS=32).
// Override BPC to exercise another radix; define DIVIDE_ROUND_EN for the
// rounding build.
module tb_divide_iter #(
  parameter int BPC = 1
);

  localparam int N_ITER = (32 + 10 + BPC - 1) / BPC;

  logic        clock;
  logic        reset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] quotient;
  logic [1:0]  flags;
  logic        out_wr_en;
  logic        out_full;

  int checks   = 0;
  int failures = 0;

  divide_iter #(
    .Q_BITS         (10),
    .D_BITS         (32),
    .BITS_PER_CYCLE (BPC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .quotient  (quotient),
    .flags     (flags),
    .out_wr_en (out_wr_en),
    .out_full  (out_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop one operand pair, wait (bounded) for the push, check latency and result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [1:0] exp_f,
                         input string tag);
    int  c;
    bit  seen;
    @(negedge clock);
    dividend = a;
    divisor  = b;
    in_empty = 1'b0;
    #1;
    check({tag, " rd_en"}, 64'(in_rd_en), 64'd1);
    @(posedge clock);
    #1 in_empty = 1'b1;
    c    = 0;
    seen = 0;
    while (!seen && c < 200) begin
      @(negedge clock);
      c++;
      if (out_wr_en === 1'b1) seen = 1;
    end
    check({tag, " latency"}, 64'(c), 64'(N_ITER + 2));
    check({tag, " quotient"}, 64'(quotient), 64'(exp_q));
    check({tag, " flags"}, 64'(flags), 64'(exp_f));
    @(posedge clock);
  endtask

  initial begin
    int pushes;
    logic [31:0] rnd_exp;

    reset    = 1'b0;
    dividend = '0;
    divisor  = '0;
    in_empty = 1'b1;
    out_full = 1'b0;

    repeat (3) @(negedge clock);
    check("reset in_rd_en", 64'(in_rd_en), 64'd0);
    check("reset out_wr_en", 64'(out_wr_en), 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run_div(32'd3072, 32'd2048, 32'd1536, 2'b00, "3/2");
    run_div(-32'sd7168, 32'd2048, -32'sd3584, 2'b00, "-7/2");
    run_div(32'd7168, -32'sd2048, -32'sd3584, 2'b00, "7/-2");
`ifdef DIVIDE_ROUND_EN
    rnd_exp = 32'd683;
`else
    rnd_exp = 32'd682;
`endif
    run_div(32'd2048, 32'd3072, rnd_exp, 2'b00, "2/3");
    run_div(32'd1024, 32'd3072, 32'd341, 2'b00, "1/3");
    run_div(32'd5120, 32'd0, 32'h7FFF_FFFF, 2'b10, "5/0");
    run_div(-32'sd5120, 32'd0, 32'h8000_0000, 2'b10, "-5/0");
    run_div(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 2'b01, "max/eps");
    run_div(32'h8000_0000, 32'd1024, 32'h8000_0000, 2'b00, "min/1");

    // Back-pressure: out_full high through WRITE while the input FIFO has data.
    @(negedge clock);
    dividend = 32'd3072;
    divisor  = 32'd2048;
    in_empty = 1'b0;
    out_full = 1'b1;
    @(posedge clock);
    #1 in_empty = 1'b1;
    repeat (N_ITER + 2) @(negedge clock);
    in_empty = 1'b0;
    dividend = 32'd1;
    divisor  = 32'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp out_wr_en", 64'(out_wr_en), 64'd0);
      check("bp in_rd_en", 64'(in_rd_en), 64'd0);
      check("bp quotient", 64'(quotient), 64'd1536);
      @(negedge clock);
    end
    out_full = 1'b0;
    in_empty = 1'b1;
    #1;
    check("bp release push", 64'(out_wr_en), 64'd1);
    @(negedge clock);
    check("bp single push", 64'(out_wr_en), 64'd0);

    // Reset mid-CALC: outputs clear, no push afterwards.
    dividend = 32'd7168;
    divisor  = 32'd2048;
    in_empty = 1'b0;
    @(posedge clock);
    #1 in_empty = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst quotient", 64'(quotient), 64'd0);
    check("midrst flags", 64'(flags), 64'd0);
    check("midrst out_wr_en", 64'(out_wr_en), 64'd0);
    @(negedge clock);
    reset  = 1'b1;
    pushes = 0;
    for (int i = 0; i < N_ITER + 5; i++) begin
      @(negedge clock);
      if (out_wr_en === 1'b1) pushes++;
    end
    check("midrst no push", 64'(pushes), 64'd0);

    run_div(32'd1024, 32'd3072, 32'd341, 2'b00, "after rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
